// File: rtl/btb_update_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : btb_update_queue                                                |
// | Brief    : Two-in / one-out coalescing FIFO feeding the BTB write port.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module btb_update_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       inA_valid,
  input  logic [AW-1:0]              inA_pc,
  input  logic [AW-1:0]              inA_target,
  input  logic                       inB_valid,
  input  logic [AW-1:0]              inB_pc,
  input  logic [AW-1:0]              inB_target,
  output logic                       full,
  output logic                       overflow,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       WE,
  output logic [AW-1:0]              PCW,
  output logic [AW-1:0]              targetW
);

  localparam int c_PW = $clog2(DEPTH);
  localparam int c_CW = $clog2(DEPTH+1);

  logic [AW-1:0]   pc_q  [DEPTH];
  logic [AW-1:0]   tgt_q [DEPTH];
  logic            vld_q [DEPTH];
  logic [c_PW-1:0] head_q, head_d;
  logic [c_PW-1:0] tail_q, tail_d;
  logic [c_CW-1:0] count_q, count_d;
  logic            ovf_q, ovf_d;

  logic [DEPTH-1:0] w_hit_a;
  logic [DEPTH-1:0] w_hit_b;
  logic             w_pop;
  logic             w_same;
  logic [AW-1:0]    w_tgt_a;
  logic             w_coal_b;
  logic             w_need_a, w_need_b;
  logic             w_alloc_a, w_alloc_b;
  logic [c_CW:0]    w_free, w_free_b;
  logic [c_PW-1:0]  w_tail_b;
  logic [1:0]       w_nalloc;

  assign w_pop = (count_q != '0);

  // The head leaving this cycle is excluded so a re-push of its PC re-allocates.
  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    logic w_live;
    assign w_live     = vld_q[i] && !(w_pop && (head_q == c_PW'(i)));
    assign w_hit_a[i] = w_live && (pc_q[i] == inA_pc);
    assign w_hit_b[i] = w_live && (pc_q[i] == inB_pc);
  end

  assign w_same   = inA_valid && inB_valid && (inA_pc == inB_pc);
  assign w_tgt_a  = w_same ? inB_target : inA_target;
  assign w_need_a = inA_valid && !(|w_hit_a);
  assign w_coal_b = inB_valid && !w_same && (|w_hit_b);
  assign w_need_b = inB_valid && !w_same && !(|w_hit_b);

  assign w_free    = (c_CW+1)'(DEPTH) - {1'b0, count_q} + {{c_CW{1'b0}}, w_pop};
  assign w_alloc_a = w_need_a && (w_free != '0);
  assign w_free_b  = w_free - {{c_CW{1'b0}}, w_alloc_a};
  assign w_alloc_b = w_need_b && (w_free_b != '0);
  assign w_tail_b  = tail_q + {{(c_PW-1){1'b0}}, w_alloc_a};
  assign w_nalloc  = {1'b0, w_alloc_a} + {1'b0, w_alloc_b};

  always_comb begin
    head_d  = head_q + {{(c_PW-1){1'b0}}, w_pop};
    tail_d  = tail_q + {{(c_PW-2){1'b0}}, w_nalloc};
    count_d = count_q - {{(c_CW-1){1'b0}}, w_pop} + {{(c_CW-2){1'b0}}, w_nalloc};
    ovf_d   = ovf_q || (w_need_a && !w_alloc_a) || (w_need_b && !w_alloc_b);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Later statements win: an allocation into the slot being popped (full queue) keeps it valid.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    always_ff @(posedge clk) begin
      if (reset) begin
        vld_q[i] <= 1'b0;
      end else begin
        if (w_pop && (head_q == c_PW'(i))) begin
          vld_q[i] <= 1'b0;
        end
        if (inA_valid && w_hit_a[i]) begin
          tgt_q[i] <= w_tgt_a;
        end
        if (w_coal_b && w_hit_b[i]) begin
          tgt_q[i] <= inB_target;
        end
        if (w_alloc_a && (tail_q == c_PW'(i))) begin
          vld_q[i] <= 1'b1;
          pc_q[i]  <= inA_pc;
          tgt_q[i] <= w_tgt_a;
        end
        if (w_alloc_b && (w_tail_b == c_PW'(i))) begin
          vld_q[i] <= 1'b1;
          pc_q[i]  <= inB_pc;
          tgt_q[i] <= inB_target;
        end
      end
    end
  end

  assign WE       = w_pop;
  assign PCW      = pc_q[head_q];
  assign targetW  = tgt_q[head_q];
  assign full     = (count_q >= c_CW'(DEPTH-1));
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_btb_update_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_btb_update_queue                                             |
// | Brief    : Self-checking bench with a queue-based reference model.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_btb_update_queue;
  localparam int DEPTH = 8;
  localparam int AW    = 16;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          reset;
  logic          inA_valid, inB_valid;
  logic [AW-1:0] inA_pc, inA_target, inB_pc, inB_target;
  logic          full, overflow, WE;
  logic [CW-1:0] count;
  logic [AW-1:0] PCW, targetW;

  int vectors     = 0;
  int miscompares = 0;

  logic [AW-1:0] qpc[$];
  logic [AW-1:0] qtg[$];
  logic          m_ovf;

  always #5 clk = ~clk;

  btb_update_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .inA_valid(inA_valid), .inA_pc(inA_pc), .inA_target(inA_target),
    .inB_valid(inB_valid), .inB_pc(inB_pc), .inB_target(inB_target),
    .full(full), .overflow(overflow), .count(count),
    .WE(WE), .PCW(PCW), .targetW(targetW)
  );

  // Sequential semantics: pop head, then apply A, then B, each coalescing or appending.
  task automatic model_push(input logic [AW-1:0] pc, input logic [AW-1:0] tgt);
    bit found = 0;
    foreach (qpc[i]) if (qpc[i] == pc) begin qtg[i] = tgt; found = 1; end
    if (!found) begin
      if (qpc.size() < DEPTH) begin qpc.push_back(pc); qtg.push_back(tgt); end
      else m_ovf = 1'b1;
    end
  endtask

  task automatic drive(input logic av, input logic [AW-1:0] ap, input logic [AW-1:0] at,
                       input logic bv, input logic [AW-1:0] bp, input logic [AW-1:0] bt);
    reset = 1'b0;
    inA_valid = av; inA_pc = ap; inA_target = at;
    inB_valid = bv; inB_pc = bp; inB_target = bt;
    @(posedge clk);
    if (qpc.size() != 0) begin void'(qpc.pop_front()); void'(qtg.pop_front()); end
    if (av) model_push(ap, at);
    if (bv) model_push(bp, bt);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    inA_valid = 1'b1; inA_pc = AW'($urandom); inA_target = AW'($urandom);
    inB_valid = 1'b1; inB_pc = AW'($urandom); inB_target = AW'($urandom);
    repeat (n) @(posedge clk);
    qpc.delete(); qtg.delete(); m_ovf = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset(2);
    vectors++; if (WE !== 1'b0)       begin miscompares++; $display("FAIL reset_we got=%0b exp=0", WE); end
    vectors++; if (count !== '0)      begin miscompares++; $display("FAIL reset_count got=%0d exp=0", count); end
    vectors++; if (full !== 1'b0)     begin miscompares++; $display("FAIL reset_full got=%0b exp=0", full); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got=%0b exp=0", overflow); end
    idle();
    vectors++; if (WE !== 1'b0)       begin miscompares++; $display("FAIL release_we got=%0b exp=0", WE); end
  endtask

  task automatic test_single();
    drive(1'b1, 16'h0104, 16'h0200, 1'b0, '0, '0);
    vectors++; if (WE !== 1'b1)          begin miscompares++; $display("FAIL single_we got=%0b exp=1", WE); end
    vectors++; if (PCW !== 16'h0104)     begin miscompares++; $display("FAIL single_pcw got=%h exp=0104", PCW); end
    vectors++; if (targetW !== 16'h0200) begin miscompares++; $display("FAIL single_tgt got=%h exp=0200", targetW); end
    vectors++; if (count !== CW'(1))     begin miscompares++; $display("FAIL single_count got=%0d exp=1", count); end
    idle();
    vectors++; if (WE !== 1'b0)          begin miscompares++; $display("FAIL single_we2 got=%0b exp=0", WE); end
    vectors++; if (count !== '0)         begin miscompares++; $display("FAIL single_count2 got=%0d exp=0", count); end
  endtask

  task automatic test_pair();
    drive(1'b1, 16'h0010, 16'h0080, 1'b1, 16'h0020, 16'h0090);
    vectors++; if (WE !== 1'b1 || PCW !== 16'h0010) begin miscompares++; $display("FAIL pair_first we=%0b pcw=%h exp=1/0010", WE, PCW); end
    vectors++; if (count !== CW'(2))                begin miscompares++; $display("FAIL pair_count got=%0d exp=2", count); end
    idle();
    vectors++; if (WE !== 1'b1 || PCW !== 16'h0020 || targetW !== 16'h0090)
      begin miscompares++; $display("FAIL pair_second we=%0b pcw=%h tgt=%h exp=1/0020/0090", WE, PCW, targetW); end
    idle();
    vectors++; if (WE !== 1'b0) begin miscompares++; $display("FAIL pair_end got=%0b exp=0", WE); end
  endtask

  task automatic test_coalesce_existing();
    drive(1'b1, 16'h0038, 16'h0001, 1'b1, 16'h0040, 16'h0002);
    drive(1'b1, 16'h0050, 16'h0003, 1'b1, 16'h0060, 16'h0004);
    vectors++; if (count !== CW'(3) || PCW !== 16'h0040) begin miscompares++; $display("FAIL coal_setup count=%0d pcw=%h exp=3/0040", count, PCW); end
    drive(1'b1, 16'h0050, 16'h0ABC, 1'b0, '0, '0);
    vectors++; if (count !== CW'(2)) begin miscompares++; $display("FAIL coal_count got=%0d exp=2", count); end
    vectors++; if (PCW !== 16'h0050 || targetW !== 16'h0ABC) begin miscompares++; $display("FAIL coal_head pcw=%h tgt=%h exp=0050/0abc", PCW, targetW); end
    idle();
    vectors++; if (PCW !== 16'h0060 || count !== CW'(1)) begin miscompares++; $display("FAIL coal_next pcw=%h count=%0d exp=0060/1", PCW, count); end
    idle();
  endtask

  task automatic test_coalesce_same();
    drive(1'b1, 16'h0030, 16'h0040, 1'b1, 16'h0030, 16'h0050);
    vectors++; if (count !== CW'(1)) begin miscompares++; $display("FAIL same_count got=%0d exp=1", count); end
    vectors++; if (PCW !== 16'h0030 || targetW !== 16'h0050) begin miscompares++; $display("FAIL same_write pcw=%h tgt=%h exp=0030/0050", PCW, targetW); end
    idle();
    vectors++; if (WE !== 1'b0) begin miscompares++; $display("FAIL same_end got=%0b exp=0", WE); end
  endtask

  task automatic test_fill_overflow();
    for (int k = 1; k <= 9; k++) begin
      drive(1'b1, AW'(16'h0100 + 2*k), AW'(16'h1000 + k), 1'b1, AW'(16'h0101 + 2*k), AW'(16'h2000 + k));
      if (k <= 6) begin
        vectors++; if (count !== CW'(k+1)) begin miscompares++; $display("FAIL fill_count k=%0d got=%0d exp=%0d", k, count, k+1); end
      end else begin
        vectors++; if (count !== CW'(8)) begin miscompares++; $display("FAIL fill_cap k=%0d got=%0d exp=8", k, count); end
      end
      vectors++; if (full !== (k >= 6)) begin miscompares++; $display("FAIL fill_full k=%0d got=%0b exp=%0b", k, full, (k >= 6)); end
    end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL fill_ovf got=%0b exp=1", overflow); end
    for (int n = 0; n < 12 && qpc.size() != 0; n++) begin
      vectors++; if (WE !== 1'b1 || PCW !== qpc[0] || targetW !== qtg[0])
        begin miscompares++; $display("FAIL drain_order n=%0d we=%0b pcw=%h tgt=%h exp=%h/%h", n, WE, PCW, targetW, qpc[0], qtg[0]); end
      idle();
    end
    vectors++; if (WE !== 1'b0 || overflow !== 1'b1) begin miscompares++; $display("FAIL drain_end we=%0b ovf=%0b exp=0/1", WE, overflow); end
    do_reset(1);
    vectors++; if (count !== '0 || overflow !== 1'b0) begin miscompares++; $display("FAIL fill_reset count=%0d ovf=%0b exp=0/0", count, overflow); end
  endtask

  task automatic test_random();
    logic av, bv;
    logic [AW-1:0] ap, bp;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset(1);
      end else begin
        av = ($urandom_range(0, 99) < 45);
        bv = ($urandom_range(0, 99) < 40);
        ap = AW'(16'h0200 + ($urandom_range(0, 11) << 2));
        bp = ($urandom_range(0, 3) == 0) ? ap : AW'(16'h0200 + ($urandom_range(0, 11) << 2));
        drive(av, ap, AW'($urandom), bv, bp, AW'($urandom));
      end
      vectors++; if (count !== CW'(qpc.size())) begin miscompares++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, count, qpc.size()); end
      vectors++; if (WE !== (qpc.size() != 0)) begin miscompares++; $display("FAIL rnd_we c=%0d got=%0b", c, WE); end
      vectors++; if (full !== (qpc.size() >= DEPTH-1)) begin miscompares++; $display("FAIL rnd_full c=%0d got=%0b", c, full); end
      vectors++; if (overflow !== m_ovf) begin miscompares++; $display("FAIL rnd_ovf c=%0d got=%0b exp=%0b", c, overflow, m_ovf); end
      if (qpc.size() != 0) begin
        vectors++; if (PCW !== qpc[0] || targetW !== qtg[0])
          begin miscompares++; $display("FAIL rnd_head c=%0d pcw=%h tgt=%h exp=%h/%h", c, PCW, targetW, qpc[0], qtg[0]); end
      end
    end
  endtask

  initial begin
    reset = 1'b1; m_ovf = 1'b0;
    inA_valid = 1'b0; inA_pc = '0; inA_target = '0;
    inB_valid = 1'b0; inB_pc = '0; inB_target = '0;
    test_reset();
    test_single();
    test_pair();
    test_coalesce_existing();
    test_coalesce_same();
    test_fill_overflow();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
